// File: rtl/median_pkg.sv
// Shared types and constants for the 5-tap streaming median filter.
package median_pkg;

  localparam int DATA_W = 4;
  localparam int WIN    = 5;
  localparam int CNT_W  = 3;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [DATA_W-1:0] sample_t;
  typedef sample_t [WIN-1:0] window_t;
  typedef logic [CNT_W-1:0]  count_t;

  function automatic count_t sat_inc(input count_t c);
    return (c == count_t'(WIN)) ? c : c + count_t'(1);
  endfunction

endpackage

// File: rtl/median_stream_5_if.sv
// Sample-in / median-out handshake bundle for median_stream_5.
// MEDIAN_STREAM_MINMAX_EN adds win_min / win_max beside median.
interface median_stream_5_if #(
  parameter int DATA_W = median_pkg::DATA_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] median;
`ifdef MEDIAN_STREAM_MINMAX_EN
  logic [DATA_W-1:0] win_min;
  logic [DATA_W-1:0] win_max;
`endif

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, median
`ifdef MEDIAN_STREAM_MINMAX_EN
    , win_min, win_max
`endif
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, median
`ifdef MEDIAN_STREAM_MINMAX_EN
    , win_min, win_max
`endif
  );

endinterface

// File: rtl/cmp_swap.sv
// Compare-exchange element: lo gets the smaller, hi the larger value.
module cmp_swap #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  logic swap;

  assign swap = a > b;
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/median_stream_5.sv
// Streaming 5-tap sliding-window median; newest sample in slot 0.
// MEDIAN_STREAM_MINMAX_EN also registers the window min and max.
module median_stream_5 #(
  parameter int DATA_W = median_pkg::DATA_W,
  parameter int WIN    = median_pkg::WIN
) (
  input logic               clk,
  input logic               rst,
  input logic               flush,
  median_stream_5_if.slave  stream
);

  import median_pkg::*;

  if (WIN != 5) begin : g_bad_win
    $error("median_stream_5: WIN must be 5");
  end
  if (DATA_W != median_pkg::DATA_W) begin : g_bad_w
    $error("median_stream_5: DATA_W must match median_pkg");
  end

  state_t  state;
  count_t  count;
  window_t win;
  window_t nxt;
  logic    accept;
  logic    clear;
  logic    produce;

  logic    out_valid;
  sample_t median;

  assign stream.in_ready  = !out_valid || stream.out_ready;
  assign stream.out_valid = out_valid;
  assign stream.median    = median;

  assign accept  = stream.in_valid && stream.in_ready;
  assign clear   = rst || flush;
  assign nxt     = {win[WIN-2:0], stream.in_data};
  assign produce = (state == RUN) ||
                   (count == count_t'(WIN - 1));

  // 9-comparator sorting network over the post-shift window
  sample_t b0, b1, b3, b4, c2, c4, d2, d3;
  sample_t e1, e4, f0, f3, g0, g2, h1, h3;
  sample_t i1, i2;

  cmp_swap #(.W(DATA_W)) u_c0 (
    .a(nxt[0]), .b(nxt[1]), .lo(b0), .hi(b1));
  cmp_swap #(.W(DATA_W)) u_c1 (
    .a(nxt[3]), .b(nxt[4]), .lo(b3), .hi(b4));
  cmp_swap #(.W(DATA_W)) u_c2 (
    .a(nxt[2]), .b(b4), .lo(c2), .hi(c4));
  cmp_swap #(.W(DATA_W)) u_c3 (
    .a(c2), .b(b3), .lo(d2), .hi(d3));
  cmp_swap #(.W(DATA_W)) u_c4 (
    .a(b1), .b(c4), .lo(e1), .hi(e4));
  cmp_swap #(.W(DATA_W)) u_c5 (
    .a(b0), .b(d3), .lo(f0), .hi(f3));
  cmp_swap #(.W(DATA_W)) u_c6 (
    .a(f0), .b(d2), .lo(g0), .hi(g2));
  cmp_swap #(.W(DATA_W)) u_c7 (
    .a(e1), .b(f3), .lo(h1), .hi(h3));
  cmp_swap #(.W(DATA_W)) u_c8 (
    .a(h1), .b(g2), .lo(i1), .hi(i2));

  // g0 = min, e4 = max, i2 = median; the rest settle mid-sort
`ifdef MEDIAN_STREAM_MINMAX_EN
  logic unused_sort;
  assign unused_sort = ^{h3, i1};

  sample_t win_min;
  sample_t win_max;

  assign stream.win_min = win_min;
  assign stream.win_max = win_max;
`else
  logic unused_sort;
  assign unused_sort = ^{h3, i1, g0, e4};
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= FILL;
      count     <= '0;
      win       <= '0;
      out_valid <= 1'b0;
      median    <= '0;
`ifdef MEDIAN_STREAM_MINMAX_EN
      win_min   <= '0;
      win_max   <= '0;
`endif
    end else begin
      if (out_valid && stream.out_ready)
        out_valid <= 1'b0;
      if (accept) begin
        win   <= nxt;
        count <= sat_inc(count);
        if (produce) begin
          state     <= RUN;
          out_valid <= 1'b1;
          median    <= i2;
`ifdef MEDIAN_STREAM_MINMAX_EN
          win_min   <= g0;
          win_max   <= e4;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_median_stream_5.sv
// Directed self-checking bench for median_stream_5.
// Min/max checks run only with MEDIAN_STREAM_MINMAX_EN.
module tb_median_stream_5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   tests = 0;
  int   fails = 0;

  median_stream_5_if ifc ();

  median_stream_5 dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .stream(ifc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d);
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    tick();
    ifc.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ifc.out_ready = 1'b1;
    do_reset();
    tests++;
    if (ifc.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: got %b want 0", ifc.out_valid);
    end
    tests++;
    if (ifc.median !== 4'd0) begin
      fails++;
      $display("FAIL reset_median: got %0d want 0", ifc.median);
    end
    tests++;
    if (ifc.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b want 1", ifc.in_ready);
    end
  endtask

  task automatic test_fill();
    logic [3:0] v [5] = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5};
    for (int i = 0; i < 4; i++) begin
      send(v[i]);
      tests++;
      if (ifc.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL fill_novalid[%0d]: got %b want 0",
                 i, ifc.out_valid);
      end
    end
    send(v[4]);
    tests++;
    if (ifc.out_valid !== 1'b1 || ifc.median !== 4'd3) begin
      fails++;
      $display("FAIL fill_first: got v=%b m=%0d want v=1 m=3",
               ifc.out_valid, ifc.median);
    end
  endtask

  task automatic test_back_to_back();
    send(4'd9);
    tests++;
    if (ifc.out_valid !== 1'b1 || ifc.median !== 4'd4) begin
      fails++;
      $display("FAIL b2b_9: got v=%b m=%0d want v=1 m=4",
               ifc.out_valid, ifc.median);
    end
    send(4'd2);
    tests++;
    if (ifc.out_valid !== 1'b1 || ifc.median !== 4'd4) begin
      fails++;
      $display("FAIL b2b_2: got v=%b m=%0d want v=1 m=4",
               ifc.out_valid, ifc.median);
    end
  endtask

  task automatic test_backpressure();
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 4'd7;
    #1;
    tests++;
    if (ifc.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_ready: got %b want 0", ifc.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (ifc.out_valid !== 1'b1 || ifc.median !== 4'd4 ||
          ifc.in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got v=%b m=%0d r=%b want 1/4/0",
                 i, ifc.out_valid, ifc.median, ifc.in_ready);
      end
    end
    ifc.out_ready = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    tests++;
    if (ifc.out_valid !== 1'b1 || ifc.median !== 4'd5) begin
      fails++;
      $display("FAIL bp_release: got v=%b m=%0d want v=1 m=5",
               ifc.out_valid, ifc.median);
    end
`ifdef MEDIAN_STREAM_MINMAX_EN
    tests++;
    if (ifc.win_min !== 4'd1 || ifc.win_max !== 4'd9) begin
      fails++;
      $display("FAIL bp_minmax: got %0d/%0d want 1/9",
               ifc.win_min, ifc.win_max);
    end
`endif
    tick();
    tests++;
    if (ifc.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain: got v=%b want 0", ifc.out_valid);
    end
  endtask

  task automatic test_extremes();
    logic [3:0] exp [3] = '{4'd15, 4'd15, 4'd0};
    do_reset();
    for (int i = 0; i < 5; i++) send(4'd15);
    tests++;
    if (ifc.out_valid !== 1'b1 || ifc.median !== 4'd15) begin
      fails++;
      $display("FAIL ext_all15: got v=%b m=%0d want v=1 m=15",
               ifc.out_valid, ifc.median);
    end
    for (int i = 0; i < 3; i++) begin
      send(4'd0);
      tests++;
      if (ifc.out_valid !== 1'b1 || ifc.median !== exp[i]) begin
        fails++;
        $display("FAIL ext_zero[%0d]: got v=%b m=%0d want v=1 m=%0d",
                 i, ifc.out_valid, ifc.median, exp[i]);
      end
    end
  endtask

  task automatic test_rst_midstream();
    logic [3:0] v [5] = '{4'd2, 4'd8, 4'd6, 4'd8, 4'd1};
    ifc.out_ready = 1'b0;
    do_reset();
    ifc.out_ready = 1'b1;
    tests++;
    if (ifc.out_valid !== 1'b0 || ifc.median !== 4'd0) begin
      fails++;
      $display("FAIL rst_pending: got v=%b m=%0d want v=0 m=0",
               ifc.out_valid, ifc.median);
    end
    send(4'd3);
    send(4'd3);
    send(4'd3);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(v[i]);
      tests++;
      if (ifc.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL rst_fill[%0d]: got v=%b want 0",
                 i, ifc.out_valid);
      end
    end
    send(v[4]);
    tests++;
    if (ifc.out_valid !== 1'b1 || ifc.median !== 4'd6) begin
      fails++;
      $display("FAIL rst_med: got v=%b m=%0d want v=1 m=6",
               ifc.out_valid, ifc.median);
    end
  endtask

  task automatic test_flush();
    logic [3:0] v [5] = '{4'd2, 4'd8, 4'd6, 4'd8, 4'd1};
    for (int i = 0; i < 5; i++) send(4'd9);
    flush        = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_data  = 4'd0;
    tick();
    flush        = 1'b0;
    ifc.in_valid = 1'b0;
    tests++;
    if (ifc.out_valid !== 1'b0 || ifc.median !== 4'd0) begin
      fails++;
      $display("FAIL flush_clear: got v=%b m=%0d want v=0 m=0",
               ifc.out_valid, ifc.median);
    end
    for (int i = 0; i < 4; i++) begin
      send(v[i]);
      tests++;
      if (ifc.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL flush_fill[%0d]: got v=%b want 0",
                 i, ifc.out_valid);
      end
    end
    send(v[4]);
    tests++;
    if (ifc.out_valid !== 1'b1 || ifc.median !== 4'd6) begin
      fails++;
      $display("FAIL flush_med: got v=%b m=%0d want v=1 m=6",
               ifc.out_valid, ifc.median);
    end
  endtask

  task automatic test_minmax();
`ifdef MEDIAN_STREAM_MINMAX_EN
    logic [3:0] v [5] = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5};
    do_reset();
    for (int i = 0; i < 5; i++) send(v[i]);
    tests++;
    if (ifc.out_valid !== 1'b1 || ifc.median !== 4'd3 ||
        ifc.win_min !== 4'd1 || ifc.win_max !== 4'd5) begin
      fails++;
      $display("FAIL minmax: got v=%b m=%0d lo=%0d hi=%0d want 1/3/1/5",
               ifc.out_valid, ifc.median, ifc.win_min, ifc.win_max);
    end
`endif
  endtask

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b1;
    test_reset();
    test_fill();
    test_back_to_back();
    test_backpressure();
    test_extremes();
    test_rst_midstream();
    test_flush();
    test_minmax();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
